// File: rtl/ones_select_pkg.sv
// Shared sizing and state encoding for the ones_select rank/select engine.
package ones_select_pkg;
    localparam int WI_SZ    = 32;
    localparam int CHUNK_SZ = 8;
    localparam int NCHUNK   = WI_SZ / CHUNK_SZ;
    localparam int IDX_SZ   = $clog2(WI_SZ);
    localparam int WO_SZ    = $clog2(WI_SZ) + 1;
    localparam int PC_SZ    = $clog2(CHUNK_SZ) + 1;
    localparam int POS_SZ   = $clog2(CHUNK_SZ);
    // A single-chunk word still needs a 1-bit pointer register.
    localparam int PTR_SZ   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    typedef enum logic [1:0] {IDLE, SCAN, DONE} ones_sel_state_t;
endpackage

// File: rtl/ones_select_chunk.sv
// Combinational per-chunk helper: popcount, and position of the r-th set bit (LSB first).
module ones_select_chunk
    import ones_select_pkg::*;
(
    input  logic [CHUNK_SZ-1:0] chunk,
    input  logic [WO_SZ-1:0]    r,
    output logic [PC_SZ-1:0]    pc,
    output logic                hit,
    output logic [POS_SZ-1:0]   pos
);
    logic [PC_SZ-1:0]  cnt;
    logic [POS_SZ-1:0] pos_c;

    always_comb begin
        cnt   = '0;
        pos_c = '0;
        for (int i = 0; i < CHUNK_SZ; i++) begin
            if (chunk[i]) begin
                cnt = cnt + 1'b1;
                if (WO_SZ'(cnt) == r) pos_c = POS_SZ'(i);
            end
        end
    end

    assign pc  = cnt;
    assign pos = pos_c;
    assign hit = (r != '0) && (r <= WO_SZ'(cnt));
endmodule

// File: rtl/ones_select.sv
// Iterative rank/select: index of the k-th set bit, one chunk per cycle.
// Define ONES_SELECT_B2B_EN to accept a new request on the edge that retires a result.
module ones_select
    import ones_select_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WI_SZ-1:0]  in_data,
    input  logic [WO_SZ-1:0]  in_rank,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [IDX_SZ-1:0] out_idx,
    output logic              out_found
);
    ones_sel_state_t   state, state_d;
    logic [PTR_SZ-1:0] ptr, ptr_d;
    logic [WO_SZ-1:0]  remaining, rem_d;
    logic [WI_SZ-1:0]  data, data_d;
    logic [IDX_SZ-1:0] idx_q, idx_d;
    logic              found_q, found_d;

    logic [CHUNK_SZ-1:0] chunk;
    logic [PC_SZ-1:0]    pc;
    logic                hit;
    logic [POS_SZ-1:0]   pos;
    logic                accept;

    assign chunk = data[ptr*CHUNK_SZ +: CHUNK_SZ];

    ones_select_chunk u_chunk (
        .chunk (chunk),
        .r     (remaining),
        .pc    (pc),
        .hit   (hit),
        .pos   (pos)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            ptr       <= '0;
            remaining <= '0;
            data      <= '0;
            idx_q     <= '0;
            found_q   <= 1'b0;
        end else begin
            state     <= state_d;
            ptr       <= ptr_d;
            remaining <= rem_d;
            data      <= data_d;
            idx_q     <= idx_d;
            found_q   <= found_d;
        end
    end

    always_comb begin
        state_d   = state;
        ptr_d     = ptr;
        rem_d     = remaining;
        data_d    = data;
        idx_d     = idx_q;
        found_d   = found_q;
        out_valid = (state == DONE);
`ifdef ONES_SELECT_B2B_EN
        in_ready  = (state == IDLE) || ((state == DONE) && out_ready);
`else
        in_ready  = (state == IDLE);
`endif
        accept    = in_valid && in_ready;

        case (state)
            SCAN: begin
                if (hit) begin
                    // ptr*CHUNK_SZ+pos is a concatenation since CHUNK_SZ is a power of two
                    idx_d   = IDX_SZ'({ptr, pos});
                    found_d = 1'b1;
                    state_d = DONE;
                end else if (ptr == PTR_SZ'(NCHUNK - 1)) begin
                    idx_d   = '0;
                    found_d = 1'b0;
                    state_d = DONE;
                end else begin
                    rem_d = remaining - WO_SZ'(pc);
                    ptr_d = ptr + 1'b1;
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: ;
        endcase

        // Acceptance overrides the DONE->IDLE retire when back-to-back is enabled.
        if (accept) begin
            data_d = in_data;
            rem_d  = in_rank;
            ptr_d  = '0;
            if (in_rank == '0) begin
                idx_d   = '0;
                found_d = 1'b0;
                state_d = DONE;
            end else begin
                state_d = SCAN;
            end
        end
    end

    assign out_idx   = idx_q;
    assign out_found = found_q;
endmodule

// File: tb/tb_ones_select.sv
// Directed self-checking bench for ones_select (WI_SZ=32, CHUNK_SZ=8).
module tb_ones_select;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic [5:0]  in_rank;
    logic        out_valid;
    logic        out_ready;
    logic [4:0]  out_idx;
    logic        out_found;

    int checks = 0;
    int errors = 0;

`ifdef ONES_SELECT_B2B_EN
    localparam int  B2B_SECOND = 3;
    localparam bit  B2B_IDLE   = 1'b0;
`else
    localparam int  B2B_SECOND = 4;
    localparam bit  B2B_IDLE   = 1'b1;
`endif

    ones_select dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_rank   (in_rank),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_idx   (out_idx),
        .out_found (out_found)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present one request; returns right after the accept edge.
    task automatic start_req(input logic [31:0] d, input logic [5:0] r, input string tag);
        @(negedge clk);
        chk({tag, "_in_ready"}, in_ready, 1'b1);
        in_valid = 1'b1;
        in_data  = d;
        in_rank  = r;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    // Latency counts the accept edge as cycle 1.
    task automatic wait_res(input string tag, output int lat);
        lat = 1;
        while (!out_valid && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!out_valid) chk({tag, "_timeout"}, 1'b0, 1'b1);
    endtask

    task automatic retire(input string tag);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk({tag, "_retired"}, out_valid, 1'b0);
    endtask

    task automatic req(input logic [31:0] d, input logic [5:0] r, input logic [4:0] eidx,
                       input logic efound, input int elat, input string tag);
        int lat;
        start_req(d, r, tag);
        wait_res(tag, lat);
        chk({tag, "_idx"}, out_idx, eidx);
        chk({tag, "_found"}, out_found, efound);
        chk({tag, "_lat"}, lat, elat);
        retire(tag);
    endtask

    initial begin
        int  lat;
        int  second_at;
        bit  seen_idle;
        bit  acc;

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_rank   = '0;
        out_ready = 1'b0;
        #12;
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_idx", out_idx, 5'd0);
        chk("rst_out_found", out_found, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        req(32'h0000_0001, 6'd1,  5'd0,  1'b1, 2, "lsb");
        req(32'h8000_0000, 6'd1,  5'd31, 1'b1, 5, "msb");
        req(32'hF0F0_F0F0, 6'd5,  5'd12, 1'b1, 3, "f0_r5");
        req(32'h0000_00FF, 6'd9,  5'd0,  1'b0, 5, "ff_r9");
        req(32'h0000_00FF, 6'd0,  5'd0,  1'b0, 1, "rank0");
        req(32'hFFFF_FFFF, 6'd32, 5'd31, 1'b1, 5, "all_r32");
        req(32'h0000_00FF, 6'd63, 5'd0,  1'b0, 5, "rank_max");
        req(32'h0000_0000, 6'd1,  5'd0,  1'b0, 5, "zero");
        req(32'h0024_0000, 6'd2,  5'd21, 1'b1, 4, "mid_r2");

        // Backpressure with a conflicting request pulse while the result waits.
        start_req(32'hF0F0_F0F0, 6'd5, "bp");
        wait_res("bp", lat);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("bp_in_ready", in_ready, 1'b0);
            if (c == 2) begin
                in_valid = 1'b1;
                in_data  = 32'h0000_0001;
                in_rank  = 6'd1;
            end
            @(posedge clk); #1;
            in_valid = 1'b0;
            chk("bp_valid", out_valid, 1'b1);
            chk("bp_idx", out_idx, 5'd12);
            chk("bp_found", out_found, 1'b1);
        end
        retire("bp");
        @(posedge clk); #1;
        chk("bp_no_ghost", out_valid, 1'b0);
        chk("bp_idle_ready", in_ready, 1'b1);

        // Reset in the middle of a scan.
        start_req(32'h8000_0000, 6'd1, "mid_rst");
        @(posedge clk); #1;
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("mid_rst_in_ready", in_ready, 1'b1);
        chk("mid_rst_valid", out_valid, 1'b0);
        chk("mid_rst_idx", out_idx, 5'd0);
        chk("mid_rst_found", out_found, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready", in_ready, 1'b1);
        req(32'h0000_0004, 6'd1, 5'd2, 1'b1, 2, "after_rst");

        // Two back-to-back requests with the consumer always ready.
        @(negedge clk);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 32'h0000_0001;
        in_rank   = 6'd1;
        @(posedge clk); #1;
        in_data   = 32'h0000_0002;
        in_rank   = 6'd1;
        chk("b2b_first_accept", in_ready, 1'b0);
        seen_idle = 1'b0;
        second_at = 0;
        for (int c = 1; c < 20 && second_at == 0; c++) begin
            @(negedge clk);
            acc = in_valid && in_ready;
            if (!out_valid && in_ready) seen_idle = 1'b1;
            @(posedge clk); #1;
            if (acc) in_valid = 1'b0;
            if (c == 1) chk("b2b_first_idx", out_idx, 5'd0);
            if (out_valid && out_idx == 5'd1 && !in_valid) second_at = c;
        end
        chk("b2b_second_cycle", second_at, B2B_SECOND);
        chk("b2b_idle_seen", seen_idle, B2B_IDLE);
        chk("b2b_second_found", out_found, 1'b1);
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("b2b_retired", out_valid, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
